// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter with a Wishbone CSR/TXDATA register pair.
// Drives the open-drain clock/data enables; all outputs are registered.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        irq,
  input  logic        iack,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe
);

  localparam int MAXAB = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int MAXC  = (MAXAB > TIMEOUT_CYCLES) ? MAXAB : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] STA_LAST = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, WAITIDLE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      nedge, nedge_n;
  logic            clk_oe_n, data_oe_n;
  logic            set_done, set_tout, set_nack;

  logic [7:0]      clk_sr;
  logic            clk_filt, fall;
  logic [1:0]      data_sync;
  logic            ready, ready_q, ie, tout, nack;
  logic [7:0]      txdata;
  logic            parity;

  logic            acc, wr, csr_wr, tx_wr;
  logic [15:0]     rd_mux;
  logic            unused_bits;

  assign unused_bits = ^{wb_adr_i[15:3], wb_adr_i[0], wb_dat_i[15:8], wb_sel_i[1]};

  assign acc    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr     = acc & wb_we_i;
  assign csr_wr = wr & (wb_adr_i[2:1] == 2'b00) & wb_sel_i[0];
  assign tx_wr  = wr & (wb_adr_i[2:1] == 2'b01) & wb_sel_i[0] & ready;
  assign parity = ~^txdata;

  always_comb begin
    rd_mux = 16'h0000;
    case (wb_adr_i[2:1])
      2'b00:   rd_mux = {8'h00, ready, ie, 4'b0000, tout, nack};
      2'b01:   rd_mux = {8'h00, txdata};
      default: rd_mux = 16'h0000;
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    nedge_n   = nedge;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    set_done  = 1'b0;
    set_tout  = 1'b0;
    set_nack  = 1'b0;
    case (state)
      IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        cnt_n     = '0;
        if (tx_wr) begin
          state_n  = INHIBIT;
          clk_oe_n = 1'b1;
        end
      end
      INHIBIT: begin
        if (cnt == INH_LAST) begin
          state_n   = START;
          cnt_n     = '0;
          data_oe_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      START: begin
        if (cnt == STA_LAST) begin
          state_n   = SHIFT;
          cnt_n     = '0;
          nedge_n   = '0;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT: begin
        cnt_n = cnt + 1'b1;
        if (fall) begin
          nedge_n = nedge + 1'b1;
          if (nedge < 4'd8)       data_oe_n = ~txdata[nedge[2:0]];
          else if (nedge == 4'd8) data_oe_n = ~parity;
          else if (nedge == 4'd9) data_oe_n = 1'b0;
          else begin
            set_nack = 1'b1;
            state_n  = WAITIDLE;
          end
        end
        // The ack edge wins over a timeout landing on the same cycle.
        if (cnt == TMO_LAST && !(fall && nedge == 4'd10)) begin
          state_n   = IDLE;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          set_tout  = 1'b1;
          set_done  = 1'b1;
        end
      end
      WAITIDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (clk_filt && data_sync[1]) begin
          set_done = 1'b1;
          state_n  = IDLE;
        end
      end
      default: begin
        state_n   = IDLE;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      clk_sr    <= 8'hFF;
      clk_filt  <= 1'b1;
      fall      <= 1'b0;
      data_sync <= 2'b11;
    end else begin
      clk_sr    <= {clk_sr[6:0], ps2_clk};
      if (&clk_sr)       clk_filt <= 1'b1;
      else if (~|clk_sr) clk_filt <= 1'b0;
      fall      <= clk_filt & ~|clk_sr;
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      nedge       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= 16'h0000;
      ready       <= 1'b1;
      ready_q     <= 1'b1;
      ie          <= 1'b0;
      tout        <= 1'b0;
      nack        <= 1'b0;
      txdata      <= 8'h00;
      irq         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      nedge       <= nedge_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      wb_ack_o    <= acc;
      if (acc) wb_dat_o <= rd_mux;
      if (csr_wr) ie <= wb_dat_i[6];
      if (tx_wr) begin
        txdata <= wb_dat_i[7:0];
        ready  <= 1'b0;
        tout   <= 1'b0;
        nack   <= 1'b0;
      end
      if (set_done) ready <= 1'b1;
      if (set_tout) tout <= 1'b1;
      if (set_nack) nack <= data_sync[1];
      ready_q <= ready;
      // Interrupt raises a cycle after READY rises; iack dominates.
      if (iack)
        irq <= 1'b0;
      else if (csr_wr && !wb_dat_i[6])
        irq <= 1'b0;
      else if ((ready && !ready_q && ie) || (csr_wr && wb_dat_i[6] && !ie && ready))
        irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Randomized bench for ps2_tx with a PS/2 device model and a register-level reference model.
module tb_ps2_tx;
  localparam int INH = 300;
  localparam int STA = 16;
  localparam int TMO = 2000;
  localparam int H   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adr = '0, dat_w = '0, dat_r;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic        ack, irq, iack = 1'b0;
  logic        clk_oe, data_oe;
  logic        dev_clk = 1'b1, dev_data = 1'b1;
  logic        line_clk, line_data;

  int errors = 0;
  int checks = 0;

  logic       m_ie, m_tout, m_nack;
  logic [7:0] m_tx;

  assign line_clk  = ~clk_oe & dev_clk;
  assign line_data = ~data_oe & dev_data;

  always #5 clk = ~clk;

  ps2_tx #(.INHIBIT_CYCLES(INH), .START_CYCLES(STA), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel), .wb_ack_o(ack),
    .irq(irq), .iack(iack), .ps2_clk(line_clk), .ps2_data(line_data),
    .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] csr_exp();
    return {8'h00, 1'b1, m_ie, 4'b0000, m_tout, m_nack};
  endfunction

  function automatic logic [10:0] frame_exp(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = a; dat_w = d; sel = s;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0; sel = 2'b00;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = a;
    @(posedge clk); #1;
    d = dat_r;
    cyc = 0; stb = 0;
  endtask

  task automatic pulse_iack();
    @(posedge clk); #1; iack = 1;
    @(posedge clk); #1; iack = 0;
  endtask

  task automatic run_phases();
    int n_inh, n_st;
    n_inh = 0; n_st = 0;
    @(negedge clk);
    while (clk_oe && !data_oe && n_inh < 20000) begin n_inh++; @(negedge clk); end
    while (clk_oe && data_oe && n_st < 20000) begin n_st++; @(negedge clk); end
    check("inhibit_cycles", n_inh, INH);
    check("start_cycles", n_st, STA);
    check("shift_entry_oe", {clk_oe, data_oe}, 2'b01);
  endtask

  task automatic run_device(input logic do_ack, input logic glitch, output logic [10:0] frame);
    for (int i = 0; i < 11; i++) begin
      if (glitch && i == 4) begin
        repeat (H/2) @(posedge clk);
        #1 dev_clk = 0;
        repeat (3) @(posedge clk);
        #1 dev_clk = 1;
        repeat (H/2) @(posedge clk);
      end else begin
        repeat (H) @(posedge clk);
      end
      #1 frame[i] = line_data;
      if (i == 10) dev_data = do_ack ? 1'b0 : 1'b1;
      dev_clk = 0;
      repeat (H) @(posedge clk);
      #1 dev_clk = 1;
    end
    repeat (H) @(posedge clk);
    #1 dev_data = 1;
  endtask

  task automatic do_xfer(input logic [7:0] b, input logic do_ack, input logic glitch,
                         input logic ie, input logic midwrite);
    logic [10:0] fr;
    logic [15:0] rd;
    int n;
    bus_wr(16'h0000, {9'd0, ie, 6'd0}, 2'b01);
    m_ie = ie;
    pulse_iack();
    bus_wr(16'h0002, {8'h00, b}, 2'b01);
    m_tx = b; m_tout = 0; m_nack = 0;
    run_phases();
    if (midwrite) bus_wr(16'h0002, 16'h0055, 2'b01);
    run_device(do_ack, glitch, fr);
    check("frame", fr, frame_exp(b));
    m_nack = ~do_ack;
    if (ie) begin
      n = 0;
      while (!irq && n < 100) begin n++; @(negedge clk); end
      check("irq_raise", irq, 1'b1);
      pulse_iack();
      @(negedge clk);
      check("irq_after_iack", irq, 1'b0);
    end else begin
      repeat (40) @(posedge clk);
      check("irq_quiet", irq, 1'b0);
    end
    check("oe_idle", {clk_oe, data_oe}, 2'b00);
    bus_rd(16'h0000, rd);
    check("csr_after", rd, csr_exp());
    bus_rd(16'h0002, rd);
    check("txdata_rd", rd, {8'h00, m_tx});
  endtask

  initial begin
    logic [15:0] rd;
    logic [10:0] fr;
    int n;
    m_ie = 0; m_tout = 0; m_nack = 0; m_tx = 8'h00;
    #3;
    check("rst_oe", {clk_oe, data_oe}, 2'b00);
    check("rst_irq_ack", {irq, ack}, 2'b00);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    bus_rd(16'h0000, rd);
    check("rst_csr", rd, 16'h0080);
    bus_rd(16'h0002, rd);
    check("rst_txdata", rd, 16'h0000);

    // Unmapped register and write without the low byte select.
    bus_wr(16'h0004, 16'h00FF, 2'b11);
    bus_rd(16'h0004, rd);
    check("reg2_rd", rd, 16'h0000);
    bus_wr(16'h0002, 16'h0033, 2'b10);
    repeat (5) @(posedge clk);
    check("sel_ignored_oe", clk_oe, 1'b0);
    bus_rd(16'h0002, rd);
    check("sel_ignored_tx", rd, 16'h0000);

    // IE rising while READY=1 raises irq.
    bus_wr(16'h0000, 16'h0040, 2'b01);
    @(negedge clk);
    check("ie_set_irq", irq, 1'b1);
    pulse_iack();
    @(negedge clk);
    check("iack_clr", irq, 1'b0);

    do_xfer(8'hED, 1'b1, 1'b0, 1'b0, 1'b0);
    do_xfer(8'hED, 1'b1, 1'b0, 1'b1, 1'b0);
    do_xfer(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    do_xfer(8'hAA, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++)
      do_xfer(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    // Timeout: device never clocks.
    bus_wr(16'h0000, 16'h0040, 2'b01);
    m_ie = 1;
    pulse_iack();
    bus_wr(16'h0002, 16'h0012, 2'b01);
    m_tx = 8'h12;
    run_phases();
    n = 0;
    while (!clk_oe && data_oe && n < 3 * TMO) begin n++; @(negedge clk); end
    check("timeout_cycles", n, TMO);
    check("timeout_oe", {clk_oe, data_oe}, 2'b00);
    m_tout = 1; m_nack = 0;
    repeat (3) @(posedge clk);
    check("timeout_irq", irq, 1'b1);
    pulse_iack();
    bus_rd(16'h0000, rd);
    check("timeout_csr", rd, csr_exp());

    // Asynchronous reset in the middle of SHIFT.
    bus_wr(16'h0002, 16'h0000, 2'b01);
    run_phases();
    for (int i = 0; i < 3; i++) begin
      repeat (H) @(posedge clk);
      #1 dev_clk = 0;
      repeat (H) @(posedge clk);
      #1 dev_clk = 1;
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("pre_rst_oe", {clk_oe, data_oe}, 2'b01);
    #2 rst = 1;
    #1 check("midrst_oe", {clk_oe, data_oe}, 2'b00);
    @(posedge clk); #1 rst = 0;
    m_ie = 0; m_tout = 0; m_nack = 0; m_tx = 8'h00;
    bus_rd(16'h0000, rd);
    check("midrst_csr", rd, csr_exp());
    check("midrst_irq", irq, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time exhausted, checks=%0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  INHIBIT_CYCLES  5000     clock-inhibit hold, >=100 us at wb_clk_i
  START_CYCLES    16       start-bit setup, data low before clock release
  TIMEOUT_CYCLES  1000000  max cycles from clock release to ack edge
REQ-002 Ports, one per line: name, direction, width, meaning.
  wb_clk_i     in   1   bus clock
  wb_rst_i     in   1   reset, asynchronous, active-high
  wb_adr_i     in   16  address; [2:1] selects register
  wb_dat_i     in   16  write data
  wb_dat_o     out  16  read data
  wb_cyc_i     in   1   bus cycle
  wb_stb_i     in   1   strobe
  wb_we_i      in   1   1=write
  wb_sel_i     in   2   byte selects
  wb_ack_o     out  1   cycle acknowledge
  irq          out  1   interrupt request
  iack         in   1   interrupt acknowledge
  ps2_clk      in   1   PS/2 clock line level
  ps2_data     in   1   PS/2 data line level
  ps2_clk_oe   out  1   1=pull PS/2 clock low (open-drain)
  ps2_data_oe  out  1   1=pull PS/2 data low (open-drain)

Function
REQ-003 Bus: wb_ack_o registered, = cyc&stb&~ack each edge; one-cycle ack, no wait states.
REQ-004 Registers by wb_adr_i[2:1]: 00 CSR, 01 TXDATA; 10/11 read 0, writes ignored.
REQ-005 CSR read: {8'h00, READY[7], IE[6], 4'b0, TOUT[1], NACK[0]}; TXDATA read: {8'h00, last written byte}.
REQ-006 CSR write with wb_sel_i[0]=1: IE <= wb_dat_i[6]; other bits read-only.
REQ-007 TXDATA write with wb_sel_i[0]=1 and READY=1: latch wb_dat_i[7:0]; READY, TOUT, NACK <= 0; IDLE->INHIBIT. Write with READY=0 ignored entirely.
REQ-008 ps2_clk filtered as in receiver: 8-stage shift register; filtered level changes only on 8 equal samples; fall = one-cycle pulse on filtered 1->0. ps2_data via 2-flop synchronizer.
REQ-009 States: IDLE, INHIBIT, START, SHIFT, WAITIDLE. IDLE: both oe=0.
REQ-010 INHIBIT: clk_oe=1, data_oe=0, exactly INHIBIT_CYCLES cycles, then START.
REQ-011 START: clk_oe=1, data_oe=1, exactly START_CYCLES cycles, then SHIFT with clk_oe=0, data_oe=1, edge count 0, timeout counter cleared.
REQ-012 SHIFT, on each fall, edge count n 1..11: n=1..8 data_oe <= ~byte[n-1] (LSB first); n=9 data_oe <= ~parity, parity = ~^byte (odd); n=10 data_oe <= 0 (stop); n=11 NACK <= synchronized ps2_data, go WAITIDLE.
REQ-013 WAITIDLE: wait for filtered clock=1 and synchronized data=1; then READY <= 1, IDLE.
REQ-014 Timeout: counter runs in SHIFT; reaching TIMEOUT_CYCLES before n=11 releases both oe, TOUT <= 1, READY <= 1, IDLE; no NACK update.
REQ-015 Completion event = READY 0->1 (normal or timeout). irq <= 1 on completion event when IE=1; irq <= 1 when IE written 0->1 while READY=1; iack=1 clears irq (priority over set); IE written 0 clears irq.
REQ-016 Outputs registered; ps2_clk_oe and ps2_data_oe never both change on same fall in SHIFT except as listed.

Reset
REQ-017 wb_rst_i=1 asynchronously: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, READY=1, IE=0, TOUT=0, NACK=0, irq=0, wb_ack_o=0, wb_dat_o=0, TXDATA=0, filter all-ones, filtered clock=1, counters 0; mid-transfer reset releases lines immediately.

Verification
REQ-018 Write 16'h00ED to TXDATA, device model clocking at 10 kHz and acking -> clk_oe high 5000 cycles, data bits 1,0,1,1,0,1,1,1 then parity 1, stop released; CSR reads 16'h0080.
REQ-019 Same with IE=1 -> irq=1 one cycle after READY rises; iack pulse -> irq=0 next cycle.
REQ-020 Device leaves data high at ack edge, byte 8'hFF -> parity 1; CSR reads 16'h0081 (NACK).
REQ-021 No device clocks after START -> TIMEOUT_CYCLES later both oe=0, CSR 16'h0082.
REQ-022 Write 8'h55 during transfer of 8'hAA -> ignored, 8'hAA sent, TXDATA reads 16'h00AA; 3-cycle glitch on ps2_clk -> no fall counted.
REQ-023 Assert wb_rst_i mid-SHIFT -> both oe=0 same cycle, CSR 16'h0080 after release.
